// File: rtl/multi_port_bus_arbiter_pkg.sv
// Shared definitions for the SDRAM bus arbiter family: command encoding,
// arbiter state encoding and the requester index width.
package multi_port_bus_arbiter_pkg;

    localparam int unsigned CMD_NOP     = 0;
    localparam int unsigned MAX_NUM_REQ = 8;
    localparam int unsigned IDX_W       = $clog2(MAX_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } arb_state_t;

endpackage

// File: rtl/multi_port_bus_arbiter_if.sv
// Request/grant and SDRAM command/data bundle between the bus masters,
// the arbiter and sdram_ctrl.
interface multi_port_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CMD_W   = 3
);
    logic                      arb_mode;
    logic [NUM_REQ-1:0]        bus_request;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*CMD_W-1:0]  req_cmd;
    logic [NUM_REQ*DATA_W-1:0] req_dataout;
    logic [DATA_W-1:0]         sdram_dataout;
    logic                      cmdack;

    logic [NUM_REQ-1:0]        bus_grant;
    logic                      grant_valid;
    logic [ADDR_W-1:0]         sdram_addr;
    logic [CMD_W-1:0]          sdram_cmd;
    logic [DATA_W-1:0]         sdram_datain;
    logic [DATA_W-1:0]         req_datain;
    logic                      hold_expired;

    modport master (
        output arb_mode, bus_request, req_addr, req_cmd, req_dataout,
               sdram_dataout, cmdack,
        input  bus_grant, grant_valid, sdram_addr, sdram_cmd, sdram_datain,
               req_datain, hold_expired
    );

    modport slave (
        input  arb_mode, bus_request, req_addr, req_cmd, req_dataout,
               sdram_dataout, cmdack,
        output bus_grant, grant_valid, sdram_addr, sdram_cmd, sdram_datain,
               req_datain, hold_expired
    );

endinterface

// File: rtl/multi_port_bus_arbiter_arb_pick.sv
// Combinational winner picker: lowest index in fixed mode, otherwise the
// first request found searching upward from i_rr_ptr+1 with wrap.
module arb_pick
    import multi_port_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    input  logic               i_mode,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic w_found;

    // Round-robin as two ascending passes (above the pointer, then at or below
    // it) so the wrap only ever visits indices below NUM_REQ.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        if (i_mode) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_found && i_req[i] && (i > 32'(i_rr_ptr))) begin
                    o_grant[i] = 1'b1;
                    o_idx      = IDX_W'(i);
                    w_found    = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (!i_mode || (i <= 32'(i_rr_ptr)))) begin
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/multi_port_bus_arbiter.sv
// NUM_REQ-way SDRAM bus arbiter: fixed-priority or round-robin grant with a
// one-cycle release gap and hold-limit preemption gated by outstanding commands.
module multi_port_bus_arbiter
    import multi_port_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CMD_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                    clk0,
    input logic                    reset,
    multi_port_bus_arbiter_if.slave bus
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_outstanding;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0] w_win;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any_req;
    logic               w_release;
    logic               w_others;
    logic               w_preempt;
    logic [ADDR_W-1:0]  w_addr;
    logic [CMD_W-1:0]   w_cmd;
    logic [DATA_W-1:0]  w_wdata;

    arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (bus.bus_request),
        .i_rr_ptr (r_rr_ptr),
        .i_mode   (bus.arb_mode),
        .o_grant  (w_win),
        .o_idx    (w_win_idx),
        .o_valid  (w_any_req)
    );

    always_comb begin
        w_addr  = '0;
        w_cmd   = '0;
        w_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_cmd   = bus.req_cmd[i*CMD_W +: CMD_W];
                w_wdata = bus.req_dataout[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_release = (r_state == OWN) && !(|(bus.bus_request & r_grant));
    assign w_others  = |(bus.bus_request & ~r_grant);
    assign w_preempt = (r_state == OWN) && !w_release && w_others && !r_outstanding &&
                       (r_hold_cnt == HOLD_W'(MAX_HOLD));

    // hold_cnt is loaded with 1 on the granting edge so it equals the owner
    // cycle number; preemption therefore lands on owner cycle MAX_HOLD.
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_hold_cnt    <= '0;
            r_outstanding <= 1'b0;
            r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (bus.cmdack)
                r_outstanding <= 1'b0;
            else if ((r_state == OWN) && (w_cmd != CMD_W'(CMD_NOP)))
                r_outstanding <= 1'b1;

            case (r_state)
                IDLE, GAP: begin
                    if (w_any_req) begin
                        r_state       <= OWN;
                        r_grant       <= w_win;
                        r_grant_valid <= 1'b1;
                        r_rr_ptr      <= w_win_idx;
                        r_hold_cnt    <= HOLD_W'(1);
                    end else begin
                        r_state       <= IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                    end
                end
                OWN: begin
                    if (w_release || w_preempt) begin
                        r_state       <= GAP;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                    end else if (r_hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_hold_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.bus_grant    = r_grant;
    assign bus.grant_valid  = r_grant_valid;
    assign bus.hold_expired = w_preempt;
    assign bus.sdram_addr   = w_addr;
    assign bus.sdram_cmd    = w_cmd;
    assign bus.sdram_datain = w_wdata;
    assign bus.req_datain   = bus.sdram_dataout;

endmodule

// File: doc/multi_port_bus_arbiter.md
Name: multi_port_bus_arbiter

Overview:
- Parametrised successor to the fixed three-requester SDRAM bus arbiter.
- Arbitrates NUM_REQ masters (dcache, icache, DMA, plus extra ports) onto the single SDRAM controller command/data path.
- Selectable fixed-priority or round-robin mode, plus a hold-limit preemption so one master cannot starve the others.
- Sits between the cache/DMA bus masters and sdram_ctrl, in the clk0 domain.

Parameters:
NUM_REQ, 4, number of requesting masters (2..8)
ADDR_W, 24, physical address width (matches padd_size)
DATA_W, 32, data width (matches data_size)
CMD_W, 3, command width (matches cmd_size); command value 0 = NOP
MAX_HOLD, 16, cycles an owner may hold the bus before preemption becomes eligible (>=2)

Ports:
clk0  in  1  system clock
reset  in  1  asynchronous, active-high reset
arb_mode  in  1  0 = fixed priority (index 0 highest), 1 = round-robin
bus_request  in  NUM_REQ  per-master request level
req_addr  in  NUM_REQ*ADDR_W  packed per-master address; master i at bits [i*ADDR_W +: ADDR_W]
req_cmd  in  NUM_REQ*CMD_W  packed per-master command
req_dataout  in  NUM_REQ*DATA_W  packed per-master write data
sdram_dataout  in  DATA_W  read data from SDRAM controller
cmdack  in  1  SDRAM controller command acknowledge (1-cycle pulse)
bus_grant  out  NUM_REQ  registered one-hot grant
grant_valid  out  1  high while any grant is active
sdram_addr  out  ADDR_W  muxed address of owner
sdram_cmd  out  CMD_W  muxed command of owner; NOP when no owner
sdram_datain  out  DATA_W  muxed write data of owner
req_datain  out  DATA_W  read data broadcast to all masters
hold_expired  out  1  1-cycle pulse when the owner is preempted

Behaviour:
- Reset (async): state IDLE; bus_grant=0; grant_valid=0; hold_expired=0; hold_cnt=0; outstanding=0; rr_ptr=NUM_REQ-1, so index 0 wins first in round-robin.
- States:
  - IDLE: if any bus_request bit is set, pick a winner and register its one-hot grant; go to OWN. Grant appears 1 cycle after the request is sampled.
  - OWN: owner holds the bus while its request stays high. hold_cnt increments each cycle and saturates at MAX_HOLD.
  - OWN exits to GAP when either:
    - the owner drops its request, or
    - preemption fires: hold_cnt==MAX_HOLD, another request is pending, and outstanding==0. Preemption also pulses hold_expired for that cycle.
  - GAP: bus_grant=0 for exactly 1 cycle (no back-to-back overlap); hold_cnt cleared; then behave as IDLE.
- Winner selection (combinational picker over bus_request, evaluated in IDLE/GAP only):
  - Fixed mode: lowest set index wins.
  - Round-robin mode: first set index searching upward from rr_ptr+1, with wrap modulo NUM_REQ. rr_ptr updates to the winner's index on every grant, in both modes.
  - arb_mode changes take effect at the next arbitration only; the current owner is never disturbed.
- Outstanding tracking:
  - outstanding is set in OWN when sdram_cmd != NOP and cmdack is not seen that cycle.
  - It is cleared on cmdack.
  - Preemption is blocked while outstanding==1. A voluntary release (request dropped) is honoured regardless of outstanding.
- Muxing (combinational from the registered grant):
  - sdram_addr/cmd/datain come from the owner's slice.
  - With no owner they are all-zero (cmd = NOP).
  - req_datain = sdram_dataout passthrough; masters qualify it with their own grant.
- Boundaries:
  - Simultaneous requests: the picker decides; losers stay pending, with no lost requests.
  - A request that drops before being granted is ignored.
  - Single requester hitting MAX_HOLD with no other pending: no preemption, and hold_cnt stays saturated.
  - Reset mid-ownership clears the grant immediately (async); sdram_cmd becomes NOP the same instant.
  - NUM_REQ not a power of two: the wrap still covers only valid indices.

Decomposition:
- Shared package:
  - CMD_NOP = 0.
  - State encoding IDLE/OWN/GAP.
  - A clog2-based index width constant.
- One sub-module, arb_pick: combinational winner selection (inputs: request vector, rr_ptr, mode; outputs: one-hot winner and winner index). It is reused by later arbiters.

Test Plan:
- Reset asserted mid-grant to master 2 -> bus_grant=0000 and sdram_cmd=0 immediately; after release, rr_ptr=3, so master 0 wins next.
- Fixed mode, bus_request=1010 in the same cycle -> bus_grant=0010 one cycle later; master 1 drops -> GAP cycle with grant 0000, then grant=1000.
- Round-robin mode, all four requesting and each dropping after 3 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with a one-cycle 0000 gap between each.
- MAX_HOLD=16, master 0 holds with master 3 pending and no outstanding command -> hold_expired pulses on owner cycle 16; master 3 is granted after the GAP.
- Preemption eligible, but master 0 issued cmd=3 and cmdack arrives 5 cycles later -> preemption is delayed until the cycle after cmdack.
- Master 1 granted: sdram_addr equals req_addr slice 1 (e.g. 0x00ABCD) and sdram_datain equals slice 1 write data; sdram_dataout=0xDEADBEEF appears on req_datain the same cycle.
